// File: rtl/prism_cfg_sequencer.sv
// Configuration loader and debug-port owner for the PRISM controller.
// Stages (addr, data) pairs, then on commit holds PRISM in debug reset,
// streams the words out, optionally reads each back, and enables the FSM.
module prism_cfg_sequencer #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned RST_CYCLES = 4,
  parameter int unsigned VERIFY_EN  = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push_valid,
  output logic                          push_ready,
  input  logic [5:0]                    push_addr,
  input  logic [31:0]                   push_data,
  input  logic                          commit,
  input  logic                          abort,
  output logic                          busy,
  output logic                          done,
  output logic                          error,
  output logic [$clog2(FIFO_DEPTH):0]   fill,
  output logic                          dbg_reset,
  output logic                          fsm_enable,
  output logic [5:0]                    dbg_addr,
  output logic                          dbg_wr,
  output logic [31:0]                   dbg_wdata,
  input  logic [31:0]                   dbg_rdata
);

  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned FW    = AW + 1;
  localparam int unsigned CNT_W = 4;
  localparam logic [FW-1:0] DEPTH_F = FW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_RESET, S_WRITE, S_VERIFY, S_ENABLE, S_ERR
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [AW-1:0]     rd_ptr, rd_ptr_nxt, wr_ptr, wr_ptr_nxt;
  logic [FW-1:0]     fill_nxt, fill_eff;
  logic [5:0]        addr_mem [FIFO_DEPTH];
  logic [31:0]       data_mem [FIFO_DEPTH];
  logic              push_fire, pop, flush;
  logic              push_ready_d, busy_d, done_d, error_d;
  logic              dbg_reset_d, fsm_enable_d, dbg_wr_d;
  logic [5:0]        dbg_addr_d;
  logic [31:0]       dbg_wdata_d;

  assign push_fire = push_valid && push_ready;

  // Staging storage; no reset needed, occupancy is tracked by pointers
  always_ff @(posedge clk) begin
    if (push_fire) begin
      addr_mem[wr_ptr] <= push_addr;
      data_mem[wr_ptr] <= push_data;
    end
  end

  // Next-state, FIFO pointer and registered-output decode
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    pop          = 1'b0;
    flush        = 1'b0;
    done_d       = 1'b0;
    dbg_wr_d     = 1'b0;
    error_d      = error;
    dbg_reset_d  = dbg_reset;
    fsm_enable_d = fsm_enable;
    dbg_addr_d   = dbg_addr;
    dbg_wdata_d  = dbg_wdata;
    fill_eff     = fill + FW'(push_fire);

    case (state)
      S_IDLE: begin
        if (commit && (fill_eff != '0)) begin
          state_nxt    = S_RESET;
          cnt_nxt      = CNT_W'(RST_CYCLES);
          dbg_reset_d  = 1'b1;
          fsm_enable_d = 1'b0;
        end
      end
      S_RESET: begin
        cnt_nxt = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) state_nxt = S_WRITE;
      end
      S_WRITE: begin
        if (VERIFY_EN != 0) begin
          state_nxt = S_VERIFY;
        end else begin
          pop       = 1'b1;
          state_nxt = (fill > FW'(1)) ? S_WRITE : S_ENABLE;
        end
      end
      S_VERIFY: begin
        if (dbg_rdata == data_mem[rd_ptr]) begin
          pop       = 1'b1;
          state_nxt = (fill > FW'(1)) ? S_WRITE : S_ENABLE;
        end else begin
          state_nxt = S_ERR;
          error_d   = 1'b1;
        end
      end
      S_ENABLE: state_nxt = S_IDLE;
      S_ERR:    state_nxt = S_ERR;
      default:  state_nxt = S_IDLE;
    endcase

    // Abort overrides everything, including a same-cycle commit
    if (abort) begin
      state_nxt    = S_IDLE;
      flush        = 1'b1;
      pop          = 1'b0;
      error_d      = 1'b0;
      dbg_reset_d  = 1'b0;
      fsm_enable_d = 1'b0;
      dbg_addr_d   = '0;
      dbg_wdata_d  = '0;
    end

    rd_ptr_nxt = flush ? '0 : (pop ? rd_ptr + AW'(1) : rd_ptr);
    wr_ptr_nxt = flush ? '0 : (push_fire ? wr_ptr + AW'(1) : wr_ptr);
    fill_nxt   = flush ? '0 : fill + FW'(push_fire) - FW'(pop);

    // Debug port drive follows the state being entered
    if (state_nxt == S_WRITE) begin
      dbg_wr_d    = 1'b1;
      dbg_addr_d  = addr_mem[rd_ptr_nxt];
      dbg_wdata_d = data_mem[rd_ptr_nxt];
    end
    if (state_nxt == S_ENABLE) begin
      dbg_reset_d  = 1'b0;
      fsm_enable_d = 1'b1;
      done_d       = 1'b1;
    end

    busy_d       = (state_nxt != S_IDLE) && (state_nxt != S_ERR);
    push_ready_d = (state_nxt == S_IDLE) && (fill_nxt < DEPTH_F);
  end

  // State, FIFO bookkeeping and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fill       <= '0;
      push_ready <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      dbg_reset  <= 1'b0;
      fsm_enable <= 1'b0;
      dbg_wr     <= 1'b0;
      dbg_addr   <= '0;
      dbg_wdata  <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      rd_ptr     <= rd_ptr_nxt;
      wr_ptr     <= wr_ptr_nxt;
      fill       <= fill_nxt;
      push_ready <= push_ready_d;
      busy       <= busy_d;
      done       <= done_d;
      error      <= error_d;
      dbg_reset  <= dbg_reset_d;
      fsm_enable <= fsm_enable_d;
      dbg_wr     <= dbg_wr_d;
      dbg_addr   <= dbg_addr_d;
      dbg_wdata  <= dbg_wdata_d;
    end
  end

endmodule

// File: tb/tb_prism_cfg_sequencer.sv
// Directed bench for prism_cfg_sequencer: default build with a PRISM
// register model, plus a no-verify / short-reset build.
module tb_prism_cfg_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Main instance (FIFO_DEPTH 8, RST_CYCLES 4, VERIFY_EN 1)
  logic        rst_n, push_valid, push_ready, commit, abort;
  logic [5:0]  push_addr, dbg_addr;
  logic [31:0] push_data, dbg_wdata, dbg_rdata;
  logic        busy, done, error, dbg_reset, fsm_enable, dbg_wr;
  logic [3:0]  fill;

  prism_cfg_sequencer dut (
    .clk(clk), .rst_n(rst_n), .push_valid(push_valid), .push_ready(push_ready),
    .push_addr(push_addr), .push_data(push_data), .commit(commit), .abort(abort),
    .busy(busy), .done(done), .error(error), .fill(fill), .dbg_reset(dbg_reset),
    .fsm_enable(fsm_enable), .dbg_addr(dbg_addr), .dbg_wr(dbg_wr),
    .dbg_wdata(dbg_wdata), .dbg_rdata(dbg_rdata)
  );

  // Second instance (VERIFY_EN 0, RST_CYCLES 1)
  logic        rst_n2, push_valid2, push_ready2, commit2, abort2;
  logic [5:0]  push_addr2, dbg_addr2;
  logic [31:0] push_data2, dbg_wdata2;
  logic [31:0] dbg_rdata2 = 32'h0;
  logic        busy2, done2, error2, dbg_reset2, fsm_enable2, dbg_wr2;
  logic [3:0]  fill2;

  prism_cfg_sequencer #(.FIFO_DEPTH(8), .RST_CYCLES(1), .VERIFY_EN(0)) dut2 (
    .clk(clk), .rst_n(rst_n2), .push_valid(push_valid2), .push_ready(push_ready2),
    .push_addr(push_addr2), .push_data(push_data2), .commit(commit2), .abort(abort2),
    .busy(busy2), .done(done2), .error(error2), .fill(fill2), .dbg_reset(dbg_reset2),
    .fsm_enable(fsm_enable2), .dbg_addr(dbg_addr2), .dbg_wr(dbg_wr2),
    .dbg_wdata(dbg_wdata2), .dbg_rdata(dbg_rdata2)
  );

  // PRISM register model: writes land on the clock, reads are combinational
  logic [31:0] prism_mem [64];
  logic [5:0]  wr_log [$];
  logic        corrupt_en = 1'b0;
  logic [5:0]  corrupt_addr = 6'h0;

  always @(posedge clk) begin
    if (dbg_wr) begin
      prism_mem[dbg_addr] <= dbg_wdata;
      wr_log.push_back(dbg_addr);
    end
  end

  assign dbg_rdata = prism_mem[dbg_addr] ^
                     ((corrupt_en && dbg_addr == corrupt_addr) ? 32'h1 : 32'h0);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Offer one entry for one cycle; called at a negedge, returns at the next
  task automatic push_one(input logic [5:0] a, input logic [31:0] d);
    push_valid = 1'b1; push_addr = a; push_data = d;
    @(negedge clk);
    push_valid = 1'b0;
  endtask

  task automatic pulse_commit();
    commit = 1'b1;
    @(negedge clk);
    commit = 1'b0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
  endtask

  initial begin
    logic [5:0]  t1_addr [3];
    logic [31:0] t1_data [3];
    int   cyc, viol, seen;
    logic got_done;

    for (int i = 0; i < 64; i++) prism_mem[i] = 32'h0;
    rst_n = 1'b0; rst_n2 = 1'b0;
    push_valid = 0; push_addr = 0; push_data = 0; commit = 0; abort = 0;
    push_valid2 = 0; push_addr2 = 0; push_data2 = 0; commit2 = 0; abort2 = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1; rst_n2 = 1'b1;
    @(negedge clk);

    // Reset state
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_fill", fill, 0);
    check("rst_dbg_reset", dbg_reset, 0);
    check("rst_fsm_enable", fsm_enable, 0);
    check("rst_dbg_wr", dbg_wr, 0);
    check("rst_dbg_addr", dbg_addr, 0);
    check("rst_dbg_wdata", dbg_wdata, 0);
    check("rst_push_ready", push_ready, 1);

    // 1: three-entry load with correct readback; done in cycle 11
    t1_addr[0] = 6'h04; t1_data[0] = 32'h11223344;
    t1_addr[1] = 6'h08; t1_data[1] = 32'h0000ABCD;
    t1_addr[2] = 6'h0C; t1_data[2] = 32'hFFFFFFFF;
    for (int i = 0; i < 3; i++) push_one(t1_addr[i], t1_data[i]);
    check("t1_fill_staged", fill, 3);
    pulse_commit();
    for (int c = 1; c <= 12; c++) begin
      check($sformatf("t1_c%0d_dbg_reset", c), dbg_reset, (c <= 10) ? 1 : 0);
      check($sformatf("t1_c%0d_dbg_wr", c), dbg_wr, (c == 5 || c == 7 || c == 9) ? 1 : 0);
      check($sformatf("t1_c%0d_done", c), done, (c == 11) ? 1 : 0);
      if (c >= 5 && c <= 10) begin
        check($sformatf("t1_c%0d_addr", c), dbg_addr, t1_addr[(c - 5) / 2]);
        if (c % 2 == 1) check($sformatf("t1_c%0d_wdata", c), dbg_wdata, t1_data[(c - 5) / 2]);
      end
      if (c == 11) begin
        check("t1_enable", fsm_enable, 1);
        check("t1_fill_end", fill, 0);
      end
      if (c == 12) begin
        check("t1_enable_held", fsm_enable, 1);
        check("t1_busy_end", busy, 0);
      end
      @(negedge clk);
    end
    for (int i = 0; i < 3; i++) check($sformatf("t1_mem%0d", i), prism_mem[t1_addr[i]], t1_data[i]);

    // 2: fill to capacity, refused 9th push, FIFO-order write-out
    for (int i = 0; i < 8; i++) push_one(6'(16 + i), 32'hA5000000 | 32'(i));
    check("t2_fill_full", fill, 8);
    check("t2_ready_full", push_ready, 0);
    push_one(6'h3F, 32'hDEADBEEF);
    check("t2_fill_after_9th", fill, 8);
    wr_log.delete();
    pulse_commit();
    cyc = 1; viol = 0; got_done = 0;
    while (cyc <= 60 && !got_done) begin
      if (busy && push_ready) viol++;
      if (done) got_done = 1;
      else begin cyc++; @(negedge clk); end
    end
    check("t2_done_seen", got_done, 1);
    check("t2_done_cycle", cyc, 21);
    check("t2_ready_while_busy", viol, 0);
    check("t2_write_count", wr_log.size(), 8);
    for (int i = 0; i < 8 && i < wr_log.size(); i++)
      check($sformatf("t2_order%0d", i), wr_log[i], 6'(16 + i));
    @(negedge clk);

    // 3: readback mismatch on the 2nd entry -> ERR until abort
    corrupt_en = 1'b1; corrupt_addr = 6'h24;
    push_one(6'h20, 32'h01020304);
    push_one(6'h24, 32'h55AA55AA);
    push_one(6'h28, 32'h0F0F0F0F);
    pulse_commit();
    cyc = 1; seen = 0;
    while (cyc <= 40 && !error) begin
      if (done) seen++;
      cyc++; @(negedge clk);
    end
    check("t3_error_set", error, 1);
    repeat (3) begin
      if (done) seen++;
      @(negedge clk);
    end
    check("t3_no_done", seen, 0);
    check("t3_error_sticky", error, 1);
    check("t3_busy", busy, 0);
    check("t3_dbg_reset", dbg_reset, 1);
    check("t3_fsm_enable", fsm_enable, 0);
    check("t3_fill", fill, 2);
    check("t3_push_ready", push_ready, 0);
    pulse_abort();
    corrupt_en = 1'b0;
    check("t3_abort_error", error, 0);
    check("t3_abort_fill", fill, 0);
    check("t3_abort_dbg_reset", dbg_reset, 0);
    check("t3_abort_busy", busy, 0);

    // 4: empty commit is a no-op; push+commit together loads one entry
    pulse_commit();
    viol = 0;
    repeat (6) begin
      if (busy || dbg_reset || dbg_wr) viol++;
      @(negedge clk);
    end
    check("t4_empty_commit_idle", viol, 0);
    push_valid = 1'b1; push_addr = 6'h30; push_data = 32'hCAFEF00D; commit = 1'b1;
    @(negedge clk);
    push_valid = 1'b0; commit = 1'b0;
    seen = 0;
    for (int c = 1; c <= 8; c++) begin
      if (done) seen = c;
      @(negedge clk);
    end
    check("t4_single_done_cycle", seen, 7);
    check("t4_single_mem", prism_mem[6'h30], 32'hCAFEF00D);
    check("t4_single_enable", fsm_enable, 1);

    // 5a: abort while in RESET
    push_one(6'h01, 32'h1);
    push_one(6'h02, 32'h2);
    pulse_commit();
    @(negedge clk);
    check("t5a_in_reset", dbg_reset, 1);
    pulse_abort();
    check("t5a_busy", busy, 0);
    check("t5a_dbg_wr", dbg_wr, 0);
    check("t5a_fsm_enable", fsm_enable, 0);
    check("t5a_fill", fill, 0);
    check("t5a_dbg_reset", dbg_reset, 0);
    viol = 0;
    repeat (15) begin
      if (done || dbg_wr) viol++;
      @(negedge clk);
    end
    check("t5a_quiet", viol, 0);

    // 5b: abort during the 2nd WRITE
    push_one(6'h38, 32'h38383838);
    push_one(6'h3C, 32'h3C3C3C3C);
    push_one(6'h3E, 32'h3E3E3E3E);
    pulse_commit();
    repeat (6) @(negedge clk);
    check("t5b_second_write", dbg_wr, 1);
    check("t5b_second_addr", dbg_addr, 6'h3C);
    pulse_abort();
    check("t5b_busy", busy, 0);
    check("t5b_dbg_wr", dbg_wr, 0);
    check("t5b_fsm_enable", fsm_enable, 0);
    check("t5b_fill", fill, 0);
    viol = 0;
    repeat (15) begin
      if (done || dbg_wr) viol++;
      @(negedge clk);
    end
    check("t5b_quiet", viol, 0);

    // 6: no-verify build, 1-cycle reset: back-to-back writes, done in cycle 4
    push_valid2 = 1'b1; push_addr2 = 6'h05; push_data2 = 32'h5;
    @(negedge clk);
    push_addr2 = 6'h06; push_data2 = 32'h6;
    @(negedge clk);
    push_valid2 = 1'b0;
    check("t6_fill", fill2, 2);
    commit2 = 1'b1;
    @(negedge clk);
    commit2 = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      check($sformatf("t6_c%0d_dbg_reset", c), dbg_reset2, (c <= 3) ? 1 : 0);
      check($sformatf("t6_c%0d_dbg_wr", c), dbg_wr2, (c == 2 || c == 3) ? 1 : 0);
      check($sformatf("t6_c%0d_done", c), done2, (c == 4) ? 1 : 0);
      if (c == 2) check("t6_addr0", dbg_addr2, 6'h05);
      if (c == 3) check("t6_addr1", dbg_addr2, 6'h06);
      @(negedge clk);
    end

    // 6b: rst_n mid-load returns everything to reset values at once
    push_valid2 = 1'b1; push_addr2 = 6'h07; push_data2 = 32'h7;
    @(negedge clk);
    push_addr2 = 6'h08; push_data2 = 32'h8;
    @(negedge clk);
    push_valid2 = 1'b0;
    commit2 = 1'b1;
    @(negedge clk);
    commit2 = 1'b0;
    @(negedge clk);
    check("t6b_mid_load_wr", dbg_wr2, 1);
    #2 rst_n2 = 1'b0;
    #1;
    check("t6b_rst_busy", busy2, 0);
    check("t6b_rst_dbg_wr", dbg_wr2, 0);
    check("t6b_rst_dbg_reset", dbg_reset2, 0);
    check("t6b_rst_fsm_enable", fsm_enable2, 0);
    check("t6b_rst_fill", fill2, 0);
    check("t6b_rst_dbg_addr", dbg_addr2, 0);
    check("t6b_rst_dbg_wdata", dbg_wdata2, 0);
    check("t6b_rst_done", done2, 0);
    check("t6b_rst_error", error2, 0);
    @(negedge clk);
    rst_n2 = 1'b1;
    @(negedge clk);
    check("t6b_after_ready", push_ready2, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
